// File: rtl/detector_jogada_pkg.sv
// Shared definitions for detector_jogada: FSM state encoding and counter sizing helper.
package detector_jogada_pkg;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    FILTRA  = 2'd1,
    CAPTURA = 2'd2,
    SOLTA   = 2'd3
  } estado_t;

  // Bits needed to represent values 0..valor-1.
  function automatic int clog2(input int valor);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < valor) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sincronizador_n.sv
// N-bit two-flop synchronizer for asynchronous inputs.
// Latency: 2 cycles from input to q.
// Backpressure: none; free-running.
module sincronizador_n #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Debounces player buttons and registers one-hot plays; optional idle timeout via DETECTOR_JOGADA_TIMEOUT_EN.
// Latency: jogada/jogada_feita valid one cycle after edge DEBOUNCE_CYCLES+2 of a stable press.
// Backpressure: none; plays are ignored while habilita is low.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES  = 5000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] botoes,
  input  logic         habilita,
  input  logic         zera,
  output logic [N-1:0] jogada,
  output logic         jogada_feita,
  output logic         invalida,
  output logic         timeout
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > TIMEOUT_CYCLES) ? DEBOUNCE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DEB_FIM = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]  s;
  logic [N-1:0]  amostra;
  logic [CW-1:0] cnt;
  estado_t       estado;
  logic          amostra_onehot;

  sincronizador_n #(.N(N)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (s)
  );

  assign amostra_onehot = (amostra != '0) && ((amostra & (amostra - N'(1))) == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= ESPERA;
      amostra      <= '0;
      cnt          <= '0;
      jogada       <= '0;
      jogada_feita <= 1'b0;
      invalida     <= 1'b0;
    end else begin
      jogada_feita <= 1'b0;
      invalida     <= 1'b0;
      // A capture assignment below overrides a coincident clear.
      if (zera) jogada <= '0;
      case (estado)
        ESPERA: begin
          if (habilita && s != '0) begin
            amostra <= s;
            cnt     <= '0;
            estado  <= FILTRA;
          end
        end
        FILTRA: begin
          if (!habilita) begin
            cnt    <= '0;
            estado <= SOLTA;
          end else if (s == '0) begin
            estado <= ESPERA;
          end else if (s != amostra) begin
            amostra <= s;
            cnt     <= '0;
          end else if (cnt == DEB_FIM) begin
            estado <= CAPTURA;
            if (amostra_onehot) begin
              jogada       <= amostra;
              jogada_feita <= 1'b1;
            end else begin
              invalida <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CAPTURA: begin
          cnt    <= '0;
          estado <= SOLTA;
        end
        SOLTA: begin
          if (s != '0) begin
            cnt <= '0;
          end else if (cnt == DEB_FIM) begin
            estado <= ESPERA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: estado <= ESPERA;
      endcase
    end
  end

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_FIM = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tcnt;

  // Counts only while idling in ESPERA with plays enabled; leaving ESPERA clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (estado == ESPERA && habilita && s == '0) begin
        if (tcnt == TMO_FIM) begin
          timeout <= 1'b1;
          tcnt    <= '0;
        end else begin
          tcnt <= tcnt + CW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=10.
module tb_detector_jogada;
  import detector_jogada_pkg::*;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int TMO = 10;

  logic         clock    = 1'b0;
  logic         reset    = 1'b1;
  logic         habilita = 1'b0;
  logic         zera     = 1'b0;
  logic [N-1:0] botoes   = '0;
  logic [N-1:0] jogada;
  logic         jogada_feita;
  logic         invalida;
  logic         timeout;

  detector_jogada #(
    .N               (N),
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes       (botoes),
    .habilita     (habilita),
    .zera         (zera),
    .jogada       (jogada),
    .jogada_feita (jogada_feita),
    .invalida     (invalida),
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    bit           inval;
    logic [N-1:0] val;
    int           cyc;
  } ev_t;

  ev_t exp_q[$];
  int  tmo_seen[$];
  bit  tmo_window = 1'b0;
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, act, exp, cyc);
  endtask

  task automatic fail(input string nome);
    n_checks++;
    $display("FAIL %s at cycle %0d (jogada=%0h feita=%0b invalida=%0b timeout=%0b)",
             nome, cyc, jogada, jogada_feita, invalida, timeout);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called right after botoes changes: capture edge is DEB+2 edges after the first sampling edge.
  task automatic expect_ev(input bit inval, input logic [N-1:0] val);
    ev_t e;
    e.inval = inval;
    e.val   = val;
    e.cyc   = cyc + DEB + 3;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (jogada_feita && invalida) fail("pulsos_simultaneos");
      if (jogada_feita || invalida) begin
        if (exp_q.size() == 0) begin
          fail("pulso_inesperado");
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("tipo_pulso", {31'd0, invalida}, {31'd0, e.inval});
          check("ciclo_pulso", cyc, e.cyc);
          if (!e.inval) check("jogada_capturada", {28'd0, jogada}, {28'd0, e.val});
        end
      end
      if (timeout) begin
        if (tmo_window) tmo_seen.push_back(cyc);
`ifndef DETECTOR_JOGADA_TIMEOUT_EN
        else fail("timeout_inesperado");
`endif
      end
    end
  end

  initial begin
    int c0;
    tick(3);
    check("reset_jogada", {28'd0, jogada}, 32'd0);
    check("reset_feita", {31'd0, jogada_feita}, 32'd0);
    check("reset_invalida", {31'd0, invalida}, 32'd0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    check("reset_estado", 32'(dut.estado), 32'(ESPERA));
    reset = 1'b0;
    habilita = 1'b1;
    tick(2);

    // Two buttons held: one invalida pulse, jogada untouched.
    botoes = 4'b0011;
    expect_ev(1'b1, 4'b0000);
    tick(12);
    botoes = 4'b0000;
    tick(8);
    check("invalida_mantem_jogada", {28'd0, jogada}, 32'd0);

    // Long hold of a single button: exactly one capture.
    botoes = 4'b0100;
    expect_ev(1'b0, 4'b0100);
    tick(20);
    botoes = 4'b0000;
    tick(10);
    check("jogada_0100", {28'd0, jogada}, 32'h4);

    // Bounce shorter than the debounce window, then stable.
    repeat (4) begin
      botoes = 4'b0001;
      tick(2);
      botoes = 4'b0000;
      tick(2);
    end
    botoes = 4'b0001;
    expect_ev(1'b0, 4'b0001);
    tick(10);
    botoes = 4'b0000;
    tick(8);
    check("jogada_apos_bounce", {28'd0, jogada}, 32'h1);

    // Disabled: no pulses.
    habilita = 1'b0;
    botoes = 4'b1000;
    tick(10);
    botoes = 4'b0000;
    tick(4);
    habilita = 1'b1;
    tick(2);

    // Enable dropped mid-filter: abort, and no capture until released.
    botoes = 4'b1000;
    tick(4);
    habilita = 1'b0;
    tick(3);
    habilita = 1'b1;
    tick(10);
    botoes = 4'b0000;
    tick(8);
    check("abort_sem_captura", {28'd0, jogada}, 32'h1);
    botoes = 4'b1000;
    expect_ev(1'b0, 4'b1000);
    tick(10);
    botoes = 4'b0000;
    tick(8);
    check("jogada_1000", {28'd0, jogada}, 32'h8);

    // zera on the capture edge: capture wins.
    botoes = 4'b0010;
    expect_ev(1'b0, 4'b0010);
    tick(6);
    zera = 1'b1;
    tick(1);
    zera = 1'b0;
    tick(6);
    botoes = 4'b0000;
    tick(8);
    check("zera_com_captura", {28'd0, jogada}, 32'h2);
    zera = 1'b1;
    tick(1);
    zera = 1'b0;
    check("zera_sozinho", {28'd0, jogada}, 32'd0);

    // Idle window with plays enabled.
    habilita = 1'b0;
    tick(1);
    habilita = 1'b1;
    c0 = cyc;
    tmo_window = 1'b1;
    tick(25);
    tmo_window = 1'b0;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    check("timeout_qtd", tmo_seen.size(), 32'd2);
    for (int i = 0; i < 2; i++)
      check("timeout_ciclo", (i < tmo_seen.size()) ? tmo_seen[i] : -1, c0 + TMO * (i + 1));
`else
    check("timeout_qtd", tmo_seen.size(), 32'd0);
    check("timeout_desligado", {31'd0, timeout}, 32'd0);
`endif

    // Reset while waiting for release.
    botoes = 4'b0100;
    expect_ev(1'b0, 4'b0100);
    tick(10);
    reset = 1'b1;
    botoes = 4'b0000;
    tick(1);
    check("reset_solta_jogada", {28'd0, jogada}, 32'd0);
    check("reset_solta_feita", {31'd0, jogada_feita}, 32'd0);
    check("reset_solta_invalida", {31'd0, invalida}, 32'd0);
    check("reset_solta_timeout", {31'd0, timeout}, 32'd0);
    check("reset_solta_estado", 32'(dut.estado), 32'(ESPERA));
    reset = 1'b0;
    tick(4);

    check("fila_vazia", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
